// File: rtl/img_sram_pkg.sv
// Shared types and default widths for the image SRAM master and its interface.
package img_sram_pkg;

    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_PIX_W    = 8;
    localparam int unsigned DEF_RD_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DUMP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_DUMP = 1'b1
    } op_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] row0;
        logic [DEF_ADDR_W-1:0] col0;
        logic [DEF_ADDR_W-1:0] nrows_m1;
        logic [DEF_ADDR_W-1:0] ncols_m1;
    } region_t;

endpackage

// File: rtl/img_sram_intf.sv
// Pin bundle of the 256x256x8 image SRAM wrapper: one slot per clock.
interface img_sram_intf
    import img_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned PIX_W  = DEF_PIX_W
) ();

    logic              clk;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [PIX_W-1:0]  din;
    logic [PIX_W-1:0]  dout;
    logic              write_en;
    logic              sense_en;

    modport master (output clk, row, col, din, write_en, sense_en, input dout);
    modport slave  (input clk, row, col, din, write_en, sense_en, output dout);

endinterface

// File: rtl/img_sram_rd_fifo.sv
// First-word-fall-through return FIFO for SRAM read data; DEPTH is a power of two.
module img_sram_rd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/img_sram_master.sv
// Sequences the image SRAM through write/read/hold slots to LOAD a region from a
// pixel stream or DUMP a region to a pixel stream, in raster order.
module img_sram_master
    import img_sram_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned PIX_W    = DEF_PIX_W,
    parameter int unsigned RD_DEPTH = DEF_RD_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_row0,
    input  logic [ADDR_W-1:0] cmd_col0,
    input  logic [ADDR_W-1:0] cmd_nrows_m1,
    input  logic [ADDR_W-1:0] cmd_ncols_m1,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [PIX_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    img_sram_intf.master      intf
);

    localparam int unsigned CNT_W = $clog2(RD_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    state_e            r_state;
    state_e            w_state_nxt;
    region_t           r_region;
    region_t           w_region_nxt;
    logic [ADDR_W-1:0] r_row_off;
    logic [ADDR_W-1:0] w_row_off_nxt;
    logic [ADDR_W-1:0] r_col_off;
    logic [ADDR_W-1:0] w_col_off_nxt;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] w_row_nxt;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] w_col_nxt;
    logic [PIX_W-1:0]  r_din;
    logic [PIX_W-1:0]  w_din_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic              r_se;
    logic              w_se_nxt;
    logic              r_inflight;
    logic              w_inflight_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_wr_ready;

    logic              w_cmd_fire;
    logic              w_wr_fire;
    logic              w_pop;
    logic              w_last_col;
    logic              w_last_pix;
    logic [ADDR_W-1:0] w_cur_row;
    logic [ADDR_W-1:0] w_cur_col;
    logic [ADDR_W-1:0] w_row_off_adv;
    logic [ADDR_W-1:0] w_col_off_adv;
    logic [OCC_W-1:0]  w_occ;
    logic              w_issue;
    logic              w_drained;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [PIX_W-1:0]  w_fifo_data;

    assign w_cmd_fire = cmd_valid && r_cmd_ready;
    assign w_wr_fire  = wr_valid && r_wr_ready;
    assign w_pop      = !w_fifo_empty && rd_ready;

    // Last-pixel detection runs on offsets so address wrap never matters.
    assign w_last_col    = (r_col_off == r_region.ncols_m1);
    assign w_last_pix    = w_last_col && (r_row_off == r_region.nrows_m1);
    assign w_cur_row     = r_region.row0 + r_row_off;
    assign w_cur_col     = r_region.col0 + r_col_off;
    assign w_col_off_adv = w_last_col ? '0 : r_col_off + ADDR_W'(1);
    assign w_row_off_adv = w_last_col ? r_row_off + ADDR_W'(1) : r_row_off;

    // Occupancy after this edge must leave room for the read issued now.
    assign w_occ     = OCC_W'(w_fifo_count) + OCC_W'(r_inflight);
    assign w_issue   = (w_occ < OCC_W'(RD_DEPTH) + OCC_W'(w_pop));
    assign w_drained = (w_occ == OCC_W'(w_pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_region_nxt   = r_region;
        w_row_off_nxt  = r_row_off;
        w_col_off_nxt  = r_col_off;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_din_nxt      = r_din;
        w_we_nxt       = 1'b0;
        w_se_nxt       = 1'b1;
        w_inflight_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                w_row_nxt = '0;
                w_col_nxt = '0;
                w_din_nxt = '0;
                if (w_cmd_fire) begin
                    w_region_nxt  = '{row0: cmd_row0, col0: cmd_col0,
                                      nrows_m1: cmd_nrows_m1, ncols_m1: cmd_ncols_m1};
                    w_row_off_nxt = '0;
                    w_col_off_nxt = '0;
                    w_state_nxt   = (op_e'(cmd_op) == OP_DUMP) ? DUMP : LOAD;
                end
            end
            LOAD: begin
                if (w_wr_fire) begin
                    w_row_nxt     = w_cur_row;
                    w_col_nxt     = w_cur_col;
                    w_din_nxt     = wr_data;
                    w_we_nxt      = 1'b1;
                    w_row_off_nxt = w_row_off_adv;
                    w_col_off_nxt = w_col_off_adv;
                    if (w_last_pix) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            DUMP: begin
                if (w_issue) begin
                    w_row_nxt      = w_cur_row;
                    w_col_nxt      = w_cur_col;
                    w_se_nxt       = 1'b0;
                    w_inflight_nxt = 1'b1;
                    w_row_off_nxt  = w_row_off_adv;
                    w_col_off_nxt  = w_col_off_adv;
                    if (w_last_pix) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_drained) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_region    <= '0;
            r_row_off   <= '0;
            r_col_off   <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_din       <= '0;
            r_we        <= 1'b0;
            r_se        <= 1'b1;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_wr_ready  <= 1'b0;
        end else begin
            r_region    <= w_region_nxt;
            r_row_off   <= w_row_off_nxt;
            r_col_off   <= w_col_off_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_din       <= w_din_nxt;
            r_we        <= w_we_nxt;
            r_se        <= w_se_nxt;
            r_inflight  <= w_inflight_nxt;
            r_done      <= w_done_nxt;
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
            r_wr_ready  <= (w_state_nxt == LOAD);
        end
    end

    // Read data is captured on the edge that closes the read slot.
    img_sram_rd_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (RD_DEPTH)
    ) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (intf.dout),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(r_inflight && w_fifo_full && !w_pop));

    assign intf.clk      = clk;
    assign intf.row      = r_row;
    assign intf.col      = r_col;
    assign intf.din      = r_din;
    assign intf.write_en = r_we;
    assign intf.sense_en = r_se;

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign wr_ready  = r_wr_ready;
    assign done      = r_done;
    assign rd_valid  = !w_fifo_empty;
    assign rd_data   = w_fifo_data;

endmodule

// File: tb/tb_img_sram_master.sv
// Directed bench for img_sram_master with a behavioural 256x256x8 SRAM model.
module tb_img_sram_master;
    import img_sram_pkg::*;

    localparam int unsigned RD_DEPTH = 2;

    typedef struct {
        string           name;
        op_e             op;
        logic [7:0]      row0;
        logic [7:0]      col0;
        logic [7:0]      nrm1;
        logic [7:0]      ncm1;
        int              npx;
        logic [5:0][7:0] px;
        logic [5:0][7:0] er;
        logic [5:0][7:0] ec;
        logic [3:0]      rdy_pat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_op;
    logic [7:0] cmd_row0, cmd_col0, cmd_nrows_m1, cmd_ncols_m1;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic log_clr = 1'b0;

    // Monitor logs, sampled mid-cycle.
    int wl_row[$], wl_col[$], wl_dat[$], wl_cyc[$];
    int rs_row[$], rs_col[$], rs_cyc[$];
    int rdat[$];
    int n_rd_slots, n_pops, max_outst, last_pop_cyc, first_rv_cyc;
    int done_cnt, done_cyc, stab_err;
    logic prev_stall;
    logic [7:0] prev_data;

    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    img_sram_intf #(.ADDR_W(8), .PIX_W(8)) u_intf ();

    img_sram_master #(.ADDR_W(8), .PIX_W(8), .RD_DEPTH(RD_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row0(cmd_row0), .cmd_col0(cmd_col0),
        .cmd_nrows_m1(cmd_nrows_m1), .cmd_ncols_m1(cmd_ncols_m1),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .intf(u_intf)
    );

    logic [7:0] sram [0:65535];
    assign u_intf.dout = sram[{u_intf.row, u_intf.col}];
    always @(posedge u_intf.clk) begin
        if (u_intf.write_en && u_intf.sense_en) sram[{u_intf.row, u_intf.col}] <= u_intf.din;
    end

    always @(negedge clk) begin
        if (log_clr || rst) begin
            wl_row.delete(); wl_col.delete(); wl_dat.delete(); wl_cyc.delete();
            rs_row.delete(); rs_col.delete(); rs_cyc.delete(); rdat.delete();
            n_rd_slots = 0; n_pops = 0; max_outst = 0; last_pop_cyc = -1;
            first_rv_cyc = -1; done_cnt = 0; done_cyc = -1; stab_err = 0;
            prev_stall = 1'b0; prev_data = 8'h00;
        end else begin
            if (u_intf.write_en && u_intf.sense_en) begin
                wl_row.push_back(int'(u_intf.row)); wl_col.push_back(int'(u_intf.col));
                wl_dat.push_back(int'(u_intf.din)); wl_cyc.push_back(cyc);
            end
            if (!u_intf.write_en && !u_intf.sense_en) begin
                rs_row.push_back(int'(u_intf.row)); rs_col.push_back(int'(u_intf.col));
                rs_cyc.push_back(cyc); n_rd_slots++;
            end
            if (n_rd_slots - n_pops > max_outst) max_outst = n_rd_slots - n_pops;
            if (rd_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
            if (prev_stall && (!rd_valid || rd_data != prev_data)) stab_err++;
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (rd_valid && rd_ready) begin
                rdat.push_back(int'(rd_data)); n_pops++; last_pop_cyc = cyc;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_clr = 1'b1;
        @(negedge clk);
        #1 log_clr = 1'b0;
    endtask

    task automatic send_cmd(input vec_t v, output int acc);
        int g = 0;
        cmd_op = v.op; cmd_row0 = v.row0; cmd_col0 = v.col0;
        cmd_nrows_m1 = v.nrm1; cmd_ncols_m1 = v.ncm1; cmd_valid = 1'b1;
        while (!cmd_ready && g < 50) begin tick(); g++; end
        check({v.name, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        while (busy && g < 200) begin tick(); g++; end
        check({nm, " idle timeout"}, 32'(busy), 32'd0);
        repeat (3) tick();
    endtask

    task automatic run_vec(input vec_t v);
        int acc;
        int k;
        int g;
        clear_logs();
        send_cmd(v, acc);
        if (v.op == OP_LOAD) begin
            for (int j = 0; j < v.npx; j++) begin
                wr_valid = 1'b1; wr_data = v.px[j];
                g = 0;
                while (!wr_ready && g < 20) begin tick(); g++; end
                check($sformatf("%s wr_ready%0d", v.name, j), 32'(wr_ready), 32'd1);
                tick();
            end
            wr_valid = 1'b0; wr_data = 8'h00;
            wait_idle(v.name);
            check({v.name, " wcount"}, 32'(wl_row.size()), 32'(v.npx));
            for (int j = 0; j < v.npx && j < wl_row.size(); j++) begin
                check($sformatf("%s wrow%0d", v.name, j), 32'(wl_row[j]), 32'(v.er[j]));
                check($sformatf("%s wcol%0d", v.name, j), 32'(wl_col[j]), 32'(v.ec[j]));
                check($sformatf("%s wdat%0d", v.name, j), 32'(wl_dat[j]), 32'(v.px[j]));
                check($sformatf("%s wcyc%0d", v.name, j), 32'(wl_cyc[j]), 32'(acc + 1 + j));
                check($sformatf("%s sram%0d", v.name, j), 32'(sram[{v.er[j], v.ec[j]}]), 32'(v.px[j]));
            end
            check({v.name, " done count"}, 32'(done_cnt), 32'd1);
            if (wl_cyc.size() > 0)
                check({v.name, " done cycle"}, 32'(done_cyc), 32'(wl_cyc[wl_cyc.size()-1]));
        end else begin
            k = 0;
            do begin
                rd_ready = v.rdy_pat[k % 4];
                tick();
                k++;
            end while (busy && k < 200);
            rd_ready = 1'b0;
            check({v.name, " dump timeout"}, 32'(busy), 32'd0);
            repeat (3) tick();
            check({v.name, " read slots"}, 32'(rs_row.size()), 32'(v.npx));
            for (int j = 0; j < v.npx && j < rs_row.size(); j++) begin
                check($sformatf("%s rrow%0d", v.name, j), 32'(rs_row[j]), 32'(v.er[j]));
                check($sformatf("%s rcol%0d", v.name, j), 32'(rs_col[j]), 32'(v.ec[j]));
            end
            check({v.name, " pops"}, 32'(rdat.size()), 32'(v.npx));
            for (int j = 0; j < v.npx && j < rdat.size(); j++)
                check($sformatf("%s rdata%0d", v.name, j), 32'(rdat[j]), 32'(v.px[j]));
            check({v.name, " first rd_valid"}, 32'(first_rv_cyc), 32'(acc + 2));
            check({v.name, " outstanding<=depth"}, 32'(max_outst <= RD_DEPTH), 32'd1);
            check({v.name, " rd_data stable"}, 32'(stab_err), 32'd0);
            check({v.name, " done count"}, 32'(done_cnt), 32'd1);
            check({v.name, " done after last pop"}, 32'(done_cyc > last_pop_cyc), 32'd1);
            if (rs_cyc.size() > 0) begin
                if (v.rdy_pat == 4'hF)
                    check({v.name, " back-to-back"}, 32'(rs_cyc[rs_cyc.size()-1] - rs_cyc[0]), 32'(v.npx - 1));
                else
                    check({v.name, " stalled"}, 32'(rs_cyc[rs_cyc.size()-1] - rs_cyc[0] > v.npx - 1), 32'd1);
            end
        end
    endtask

    function automatic vec_t mk(input string nm, input op_e op, input logic [7:0] r0, input logic [7:0] c0,
                                input logic [7:0] nr, input logic [7:0] nc, input int n,
                                input logic [47:0] px, input logic [47:0] er, input logic [47:0] ec,
                                input logic [3:0] pat);
        vec_t v;
        v.name = nm; v.op = op; v.row0 = r0; v.col0 = c0; v.nrm1 = nr; v.ncm1 = nc;
        v.npx = n; v.px = px; v.er = er; v.ec = ec; v.rdy_pat = pat;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [47:0] px6, er6, ec6, pxw, erw, ecw;
        px6 = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        er6 = {8'd11, 8'd11, 8'd11, 8'd10, 8'd10, 8'd10};
        ec6 = {8'd22, 8'd21, 8'd20, 8'd22, 8'd21, 8'd20};
        pxw = {8'h00, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        erw = {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255};
        ecw = {8'd0, 8'd0, 8'd255, 8'd254, 8'd255, 8'd254};
        vecs[0] = mk("load2x3",   OP_LOAD, 8'd10,  8'd20,  8'd1, 8'd2, 6, px6, er6, ec6, 4'hF);
        vecs[1] = mk("loadwrap",  OP_LOAD, 8'd255, 8'd254, 8'd1, 8'd1, 4, pxw, erw, ecw, 4'hF);
        vecs[2] = mk("dump2x3",   OP_DUMP, 8'd10,  8'd20,  8'd1, 8'd2, 6, px6, er6, ec6, 4'hF);
        vecs[3] = mk("dumptoggle",OP_DUMP, 8'd10,  8'd20,  8'd1, 8'd2, 6, px6, er6, ec6, 4'b1001);
        vecs[4] = mk("dumpwrap",  OP_DUMP, 8'd255, 8'd254, 8'd1, 8'd1, 4, pxw, erw, ecw, 4'hF);
        vecs[5] = mk("loadpost",  OP_LOAD, 8'd5,   8'd5,   8'd0, 8'd1, 2,
                     {32'd0, 8'h88, 8'h77}, {32'd0, 8'd5, 8'd5}, {32'd0, 8'd6, 8'd5}, 4'hF);
        vecs[6] = mk("dumppost",  OP_DUMP, 8'd5,   8'd5,   8'd0, 8'd1, 2,
                     {32'd0, 8'h88, 8'h77}, {32'd0, 8'd5, 8'd5}, {32'd0, 8'd6, 8'd5}, 4'hF);

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_row0 = '0; cmd_col0 = '0;
        cmd_nrows_m1 = '0; cmd_ncols_m1 = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) tick();
        check("rst write_en", 32'(u_intf.write_en), 32'd0);
        check("rst sense_en", 32'(u_intf.sense_en), 32'd1);
        check("rst row/col/din", {8'h00, u_intf.row, u_intf.col, u_intf.din}, 32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst busy/done/wr_ready/rd_valid", {28'd0, busy, done, wr_ready, rd_valid}, 32'd0);
        check("rst rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        check("idle hold", {30'd0, u_intf.write_en, u_intf.sense_en}, 32'd1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Second command held during a stalled DUMP, then reset mid-operation.
        begin
            int acc;
            clear_logs();
            rd_ready = 1'b0;
            send_cmd(vecs[2], acc);
            cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_row0 = 8'd200; cmd_col0 = 8'd0;
            for (int i = 0; i < 4; i++) begin
                tick();
                check($sformatf("held cmd_ready%0d", i), 32'(cmd_ready), 32'd0);
                check($sformatf("held busy%0d", i), 32'(busy), 32'd1);
            end
            check("held no writes", 32'(wl_row.size()), 32'd0);
            check("held head valid", 32'(rd_valid), 32'd1);
            check("held head data", 32'(rd_data), 32'd1);
            rst = 1'b1;
            #1;
            check("midrst write_en", 32'(u_intf.write_en), 32'd0);
            check("midrst sense_en", 32'(u_intf.sense_en), 32'd1);
            check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
            check("midrst busy", 32'(busy), 32'd0);
            check("midrst rd_valid", 32'(rd_valid), 32'd0);
            check("midrst rd_data", 32'(rd_data), 32'd0);
            cmd_valid = 1'b0;
            repeat (2) tick();
            rst = 1'b0;
            tick();
        end
        run_vec(vecs[5]);
        run_vec(vecs[6]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
